// File: rtl/draw_arbiter.sv
// draw_arbiter: shares one VGA pixel port between four draw engines
// (bg, ship, asteroids, score). A winner is picked from the level requests,
// handed a one-cycle start pulse, and owns the pixel port until it pulses
// done or the watchdog forces a release.
//
// Build option: define DRAW_ARB_ROUND_ROBIN_EN for round-robin arbitration
// that starts after the last winner; leave it undefined for fixed priority
// with engine 0 highest.

module draw_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [3:0]  done_in,
  input  logic [31:0] x_in,
  input  logic [27:0] y_in,
  input  logic [11:0] c_in,
  input  logic [3:0]  plot_in,
  output logic [3:0]  start_out,
  output logic [3:0]  grant,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_c,
  output logic        vga_plot,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_DRAW    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;   // index form of grant_q, drives the muxes
  logic [15:0] wd_q, wd_d;
  logic        tout_q, tout_d;

  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_c_q, vga_c_d;
  logic        vga_plot_q, vga_plot_d;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_c;
  logic        sel_plot;
  logic        sel_done;
  logic [1:0]  winner;

`ifdef DRAW_ARB_ROUND_ROBIN_EN
  logic [1:0]  last_q, last_d;

  // First asserted request scanning upward from last+1, wrapping 3->0.
  // Scanning k from far to near lets the nearest hit overwrite the rest.
  function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                             input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    win = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign winner = pick_winner(req, last_q);
`else
  // Fixed priority: engine 0 (background) always wins.
  function automatic logic [1:0] pick_winner(input logic [3:0] r);
    logic [1:0] win;
    if (r[0])      win = 2'd0;
    else if (r[1]) win = 2'd1;
    else if (r[2]) win = 2'd2;
    else           win = 2'd3;
    return win;
  endfunction

  assign winner = pick_winner(req);
`endif

  // Route the owning engine's pixel bus and done bit; others are ignored.
  always_comb begin
    sel_x    = x_in[7:0];
    sel_y    = y_in[6:0];
    sel_c    = c_in[2:0];
    sel_plot = plot_in[0];
    sel_done = done_in[0];
    case (owner_q)
      2'd0: begin
        sel_x    = x_in[7:0];
        sel_y    = y_in[6:0];
        sel_c    = c_in[2:0];
        sel_plot = plot_in[0];
        sel_done = done_in[0];
      end
      2'd1: begin
        sel_x    = x_in[15:8];
        sel_y    = y_in[13:7];
        sel_c    = c_in[5:3];
        sel_plot = plot_in[1];
        sel_done = done_in[1];
      end
      2'd2: begin
        sel_x    = x_in[23:16];
        sel_y    = y_in[20:14];
        sel_c    = c_in[8:6];
        sel_plot = plot_in[2];
        sel_done = done_in[2];
      end
      default: begin
        sel_x    = x_in[31:24];
        sel_y    = y_in[27:21];
        sel_c    = c_in[11:9];
        sel_plot = plot_in[3];
        sel_done = done_in[3];
      end
    endcase
  end

  // State register plus the control registers that move with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= 4'd0;
      owner_q <= 2'd0;
      wd_q    <= 16'd0;
      tout_q  <= 1'b0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
      last_q  <= 2'd3;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      tout_q  <= tout_d;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state logic: arbitration, watchdog and release bookkeeping.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    wd_d    = 16'd0;
    tout_d  = 1'b0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req != 4'd0) begin
          owner_d = winner;
          grant_d = 4'd1 << winner;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // done takes precedence over a simultaneous watchdog expiry
        if (sel_done) begin
          state_d = S_RELEASE;
        end else if (wd_q == TIMEOUT - 16'd1) begin
          state_d = S_RELEASE;
          tout_d  = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_RELEASE: begin
        grant_d = 4'd0;
`ifdef DRAW_ARB_ROUND_ROBIN_EN
        last_d  = owner_q;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'd0;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    start_out   = (state_q == S_START) ? grant_q : 4'd0;
    busy        = (state_q != S_IDLE);
    grant       = grant_q;
    timeout_err = tout_q;
    vga_x       = vga_x_q;
    vga_y       = vga_y_q;
    vga_c       = vga_c_q;
    vga_plot    = vga_plot_q;
  end

  // Pixel capture: zero whenever the port has no owner in the coming cycle,
  // so the registered pixel port reads 0 exactly while grant reads 0.
  always_comb begin
    vga_x_d    = 8'd0;
    vga_y_d    = 7'd0;
    vga_c_d    = 3'd0;
    vga_plot_d = 1'b0;
    if ((grant_q != 4'd0) && (grant_d != 4'd0)) begin
      vga_x_d    = sel_x;
      vga_y_d    = sel_y;
      vga_c_d    = sel_c;
      vga_plot_d = sel_plot;
    end
  end

  // Pixel port register, one cycle behind the owning engine.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
      vga_c_q    <= 3'd0;
      vga_plot_q <= 1'b0;
    end else begin
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_c_q    <= vga_c_d;
      vga_plot_q <= vga_plot_d;
    end
  end

endmodule
